denormalization: RTL and testbench



---
 rtl/norm_pkg.sv | 23 ++
 rtl/seq_udiv.sv | 77 +++++++
 rtl/denormalization.sv | 124 ++++++++++++
 tb/tb_denormalization.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Range constants shared by the pixel normalizer and the denormalization
// block, so that both ends map pixels against the same [NORM_MIN, NORM_MAX]
// range. It also holds the state type for the denormalization FSM.
// -----------------------------------------------------------------------------
package norm_pkg;

    localparam int NORM_WIDTH = 20;     // filter-domain values are signed [NORM_WIDTH:0]
    localparam int PIX_W      = 8;      // normalized pixel width
    localparam int NORM_MAX   = 1530;   // 255*6
    localparam int NORM_MIN   = -510;   // -255*2
    localparam int NORM_SCALE = 255;    // normalized full-scale value
    localparam int NORM_NUM_W = 20;     // numerator / divider iteration width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        HOLD = 2'd3
    } denorm_state_t;

endpackage

// File: rtl/seq_udiv.sv
// -----------------------------------------------------------------------------
// seq_udiv
// Bit-serial restoring unsigned divider that produces one quotient bit per
// cycle, MSB first. It takes NUM_W cycles after start. The divisor must stay
// constant while busy.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   load num and begin dividing (ignored while busy)
//   num    in   [NUM_W-1:0] dividend
//   den    in   [DEN_W-1:0] divisor, nonzero
//   busy   out  a division is in progress
//   done   out  high during the final iteration cycle
//   quo    out  [NUM_W-1:0] full quotient, valid only while done is high
// -----------------------------------------------------------------------------
module seq_udiv #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    // The dividend shifts out of the MSB while quotient bits shift into the
    // LSB. After NUM_W steps the register holds only the quotient.
    logic [NUM_W-1:0] shreg_q;
    logic [DEN_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [DEN_W:0]   rem_sh;
    logic             take;
    logic [DEN_W-1:0] rem_nx;

    // The remainder is always below den, so the shifted value fits in DEN_W+1 bits.
    assign rem_sh = {rem_q, shreg_q[NUM_W-1]};
    assign take   = (rem_sh >= {1'b0, den});
    assign rem_nx = DEN_W'(take ? (rem_sh - {1'b0, den}) : rem_sh);

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign quo  = {shreg_q[NUM_W-2:0], take};

    always_ff @(posedge clk) begin
        // NOTE: registered state is assigned with <= only, so every flop
        // samples the values from before the clock edge.
        if (reset) begin
            shreg_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start && !busy_q) begin
            shreg_q <= num;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(NUM_W - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shreg_q <= quo;
            rem_q   <= rem_nx;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/denormalization.sv
// -----------------------------------------------------------------------------
// denormalization
// Maps an 8-bit normalized pixel back into the signed filter domain:
//   out = MIN + round(pix * (MAX - MIN) / SCALE), with rounding half up.
// It accepts one pixel at a time. A result appears NUM_W+2 cycles after the
// accept and is held until the consumer takes it.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   pixel present
//   in_ready   out  block can accept a pixel
//   pix        in   [PIX_W-1:0] unsigned normalized pixel
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   out        out  [NORM_WIDTH:0] signed denormalized value
// -----------------------------------------------------------------------------
module denormalization
    import norm_pkg::*;
#(
    parameter int NORM_WIDTH = norm_pkg::NORM_WIDTH,
    parameter int PIX_W      = norm_pkg::PIX_W,
    parameter int MAX        = norm_pkg::NORM_MAX,
    parameter int MIN        = norm_pkg::NORM_MIN,
    parameter int SCALE      = norm_pkg::NORM_SCALE,
    parameter int NUM_W      = norm_pkg::NORM_NUM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_W-1:0]    pix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NORM_WIDTH:0] out
);

    localparam int OUT_W = NORM_WIDTH + 1;

    localparam logic [NUM_W-1:0] RANGE_N = NUM_W'(MAX - MIN);
    localparam logic [NUM_W-1:0] HALF_N  = NUM_W'(SCALE / 2);
    localparam logic [OUT_W-1:0] MIN_V   = OUT_W'(MIN);

    if (MAX <= MIN) begin : g_bad_range
        $error("denormalization: MAX must be greater than MIN");
    end
    if ((longint'(SCALE) * (MAX - MIN) + SCALE / 2) >= (longint'(1) << NUM_W)) begin : g_bad_num_w
        $error("denormalization: NUM_W too narrow for SCALE*(MAX-MIN)+SCALE/2");
    end
    if ((longint'(MAX) >= (longint'(1) << NORM_WIDTH)) ||
        (longint'(MIN) < -(longint'(1) << NORM_WIDTH))) begin : g_bad_out_w
        $error("denormalization: MAX/MIN do not fit in signed NORM_WIDTH+1 bits");
    end
    if ((SCALE <= 0) || (longint'(SCALE) >= (longint'(1) << PIX_W))) begin : g_bad_scale
        $error("denormalization: SCALE must be positive and fit in PIX_W bits");
    end

    denorm_state_t    state_q, state_d;
    logic [PIX_W-1:0] pix_q;
    logic [OUT_W-1:0] out_q;

    logic [NUM_W-1:0] num;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_quo;

    // The bound on NUM_W guarantees that this product never overflows.
    assign num = NUM_W'(pix_q) * RANGE_N + HALF_N;

    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (PIX_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (num),
        .den   (PIX_W'(SCALE)),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;

    always_comb begin
        // NOTE: the defaults come first so that every path assigns every
        // output. Without them the tools would infer latches.
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: if (in_valid) state_d = MUL;
            MUL: begin
                div_start = !div_busy;
                state_d   = DIV;
            end
            DIV:  if (div_done) state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pix_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_valid && in_ready) begin
                pix_q <= pix;
            end
            // The quotient never exceeds MAX-MIN, so the offset add cannot
            // leave the output range.
            if ((state_q == DIV) && div_done) begin
                out_q <= MIN_V + OUT_W'(div_quo);
            end
        end
    end

endmodule

// File: tb/tb_denormalization.sv
// -----------------------------------------------------------------------------
// tb_denormalization
// Scoreboard bench for denormalization. Each accepted pixel pushes its
// expected value, computed from the rounding rule, and its accept cycle into
// a queue. A monitor pops entries and compares them against the results the
// DUT hands over. A second instance with MAX=1000, MIN=-200 covers rounding
// for a non-default range.
// -----------------------------------------------------------------------------
module tb_denormalization;

    localparam int NUM_W = 20;
    localparam int SCALE = 255;
    localparam int D_MAX = 1530;
    localparam int D_MIN = -510;
    localparam int A_MAX = 1000;
    localparam int A_MIN = -200;

    typedef struct {
        int exp;
        int t0;
    } item_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         pix = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [20:0] dout;

    logic               alt_in_valid = 1'b0;
    logic               alt_in_ready;
    logic [7:0]         alt_pix = '0;
    logic               alt_out_valid;
    logic               alt_out_ready = 1'b1;
    logic signed [20:0] alt_out;

    int    n_vec = 0;
    int    n_err = 0;
    int    n_out = 0;
    int    cyc = 0;
    int    cur_exp = 0;
    int    rdy_mode = 0;    // 0: always ready, 1: random, 2: stalled
    bit    b2b = 1'b0;
    bit    b2b_seen = 1'b0;
    int    last_acc = 0;
    bit    ov_prev = 1'b0;
    bit    or_prev = 1'b0;
    int    out_prev = 0;
    item_t sb_q[$];

    denormalization dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix       (pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    denormalization #(
        .MAX (A_MAX),
        .MIN (A_MIN)
    ) dut_alt (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (alt_in_valid),
        .in_ready  (alt_in_ready),
        .pix       (alt_pix),
        .out_valid (alt_out_valid),
        .out_ready (alt_out_ready),
        .out       (alt_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: MIN + floor(pix*range/SCALE + 1/2), in exact integer arithmetic.
    function automatic int model(input int p, input int mx, input int mn);
        return mn + (2 * p * (mx - mn) + SCALE) / (2 * SCALE);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Consumer-side ready pattern, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready <= 1'b1;
            1:       out_ready <= 1'($urandom_range(0, 1));
            default: out_ready <= 1'b0;
        endcase
    end

    // Accept monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            sb_q.push_back('{cur_exp, cyc + 1});
            if (b2b && b2b_seen) check("accept_spacing", cyc + 1 - last_acc, NUM_W + 3);
            b2b_seen <= b2b;
            last_acc <= cyc + 1;
        end
    end

    // Output monitor: latency, hold stability and result ordering.
    always @(negedge clk) begin
        if (reset) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                check("pending_at_output", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) check("latency", cyc + 1 - sb_q[0].t0, NUM_W + 2);
            end
            if (ov_prev && !or_prev && out_valid) check("hold_stable", int'(dout), out_prev);
            if (out_valid && out_ready && sb_q.size() > 0) begin
                check("result", int'(dout), sb_q[0].exp);
                void'(sb_q.pop_front());
                n_out <= n_out + 1;
            end
            ov_prev  <= out_valid;
            or_prev  <= out_ready;
            out_prev <= int'(dout);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. Returns just after the accepting edge.
    task automatic send(input int p, input int e);
        in_valid = 1'b1;
        pix      = 8'(p);
        cur_exp  = e;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_within_budget", int'(in_ready), 1);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", sb_q.size(), 0);
        sync();
    endtask

    task automatic wait_out_valid(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(name, int'(out_valid), 1);
    endtask

    task automatic alt_run(input int p, input int e);
        alt_in_valid = 1'b1;
        alt_pix      = 8'(p);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (alt_in_ready) break;
        end
        sync();
        alt_in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (alt_out_valid) break;
        end
        check("alt_out_valid_seen", int'(alt_out_valid), 1);
        check("alt_result", int'(alt_out), e);
        sync();
    endtask

    initial begin
        int base;
        int p;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out", int'(dout), 0);
        sync();

        // First transfer, followed by the no-bypass check.
        send(0, -510);
        wait_out_valid("first_out_valid");
        check("no_bypass_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("ready_after_handshake", int'(in_ready), 1);
        check("valid_after_handshake", int'(out_valid), 0);
        sync();

        send(255, 1530); drain();
        send(128, 514);  drain();
        send(1, -502);   drain();

        // Backpressure, with a stray in_valid pulse while the result is held.
        rdy_mode = 2;
        send(10, -430);
        wait_out_valid("bp_out_valid");
        base = n_out;
        for (int i = 0; i < 15; i++) begin
            sync();
            in_valid = (i == 4);
            pix      = 8'd99;
            cur_exp  = model(99, D_MAX, D_MIN);
            @(negedge clk);
            if (i == 4) check("bp_in_ready", int'(in_ready), 0);
        end
        check("bp_out_held", int'(dout), -430);
        check("bp_valid_held", int'(out_valid), 1);
        rdy_mode = 0;
        drain();
        repeat (30) @(posedge clk);
        check("bp_one_transfer", n_out - base, 1);
        sync();

        // Reset in the middle of a divide discards the in-flight pixel.
        send(77, model(77, D_MAX, D_MIN));
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        sync();
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("post_reset_in_ready", int'(in_ready), 1);
        check("post_reset_out_valid", int'(out_valid), 0);
        repeat (40) @(negedge clk);
        sync();
        send(255, 1530);
        drain();

        // Back-to-back accepts with in_valid held high.
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p = int'($urandom_range(0, 255));
            send(p, model(p, D_MAX, D_MIN));
            if (i < 3) in_valid = 1'b1;
        end
        drain();
        b2b = 1'b0;

        // Non-default range.
        alt_run(100, 271);
        alt_run(255, 1000);
        alt_run(0, -200);
        alt_run(37, model(37, A_MAX, A_MIN));

        // Full sweep, then random pixels, with random backpressure and gaps.
        rdy_mode = 1;
        for (int i = 0; i < 256; i++) begin
            send(i, model(i, D_MAX, D_MIN));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(0, 255));
            send(p, model(p, D_MAX, D_MIN));
        end
        drain();
        rdy_mode = 0;

        repeat (30) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
